// File: rtl/client_sink.sv
// NoC receive endpoint: skid FIFO, throttled drain, packet-id check; 2-cycle min c_i_v->rx_count.
// Backpressure is advisory: c_i_bp rises at DEPTH-SKID occupancy, packets arriving when full are dropped and flagged.
module client_sink #(
  parameter int N          = 2,
  parameter int D_W        = 32,
  parameter int A_W        = $clog2(N) + 1,
  parameter int POSX       = 0,
  parameter int LIMIT      = 16,
  parameter int EXPECTED   = 16,
  parameter int DEPTH      = 8,
  parameter int SKID       = 2,
  parameter int DRAIN_RATE = 100
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic [A_W+D_W:0] c_i,
  input  logic             c_i_v,
  output logic             c_i_bp,
  output logic [31:0]      rx_count,
  output logic             err,
  output logic [2:0]       err_code,
  output logic             done
);

  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = AW + 1;
  localparam int LW  = $clog2(LIMIT);
  localparam int SW  = $clog2(N * LIMIT);
  localparam int E_W = A_W + D_W;

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] BP_THR   = CW'(DEPTH - SKID);

  localparam logic [2:0] C_MISROUTE = 3'd1;
  localparam logic [2:0] C_BAD_SRC  = 3'd2;
  localparam logic [2:0] C_DUP      = 3'd4;
  localparam logic [2:0] C_OVERFLOW = 3'd5;
  localparam logic [2:0] C_EXTRA    = 3'd6;

  typedef enum logic [1:0] {S_RUN, S_DONE, S_ERROR} state_t;
  state_t state, state_d;

  logic [E_W-1:0]   mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count, count_nxt;
  logic [15:0]      lfsr, lfsr_mod;
  logic             lfsr_fb, rate_ok, push, pop, full, ovf;

  logic             chk_vld, chk_fire;
  logic [A_W-1:0]   chk_dst;
  logic [D_W-1:0]   chk_dat, chk_src;
  logic [SW-1:0]    sb_idx;
  logic [N*LIMIT-1:0] sb;
  logic             src_ok, dup;
  logic [2:0]       chk_code, evt_code;
  logic             err_evt;

  logic unused_flag;
  assign unused_flag = c_i[E_W];

  // Drain throttle: Fibonacci LFSR, taps 16,14,13,11
  assign lfsr_fb  = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
  assign lfsr_mod = lfsr % 16'd100;
  assign rate_ok  = lfsr_mod < 16'(DRAIN_RATE);

  assign full = (count == FULL_CNT);
  assign pop  = ce && (count != '0) && rate_ok;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push = c_i_v && (!full || pop);
  assign ovf  = c_i_v && full && !pop;

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
  end

  // src*LIMIT+seq equals the raw id because LIMIT is a power of two
  assign chk_fire = chk_vld && ce;
  assign chk_src  = chk_dat >> LW;
  assign sb_idx   = chk_dat[SW-1:0];
  assign src_ok   = chk_src < D_W'(N);
  assign dup      = src_ok && sb[sb_idx];

  always_comb begin
    chk_code = 3'd0;
    if (chk_fire) begin
      if (chk_dst != A_W'(POSX))                  chk_code = C_MISROUTE;
      else if (!src_ok || chk_src == D_W'(POSX))  chk_code = C_BAD_SRC;
      else if (dup)                               chk_code = C_DUP;
      else if (state == S_DONE)                   chk_code = C_EXTRA;
    end
  end

  // The checked packet is older than the overflowing one, so its error wins.
  assign err_evt  = (chk_code != 3'd0) || ovf;
  assign evt_code = (chk_code != 3'd0) ? chk_code : C_OVERFLOW;

  always_comb begin
    state_d = state;
    case (state)
      S_RUN: begin
        if (err_evt)
          state_d = S_ERROR;
        else if (rx_count == 32'(EXPECTED) && count == '0 && !chk_vld)
          state_d = S_DONE;
      end
      S_DONE:  if (err_evt) state_d = S_ERROR;
      default: state_d = S_ERROR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_RUN;
    else     state <= state_d;
  end

  assign done = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= c_i[E_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      c_i_bp   <= 1'b0;
      lfsr     <= 16'hACE1;
      chk_vld  <= 1'b0;
      chk_dst  <= '0;
      chk_dat  <= '0;
      rx_count <= '0;
      err      <= 1'b0;
      err_code <= 3'd0;
      sb       <= '0;
    end else begin
      lfsr   <= {lfsr[14:0], lfsr_fb};
      count  <= count_nxt;
      c_i_bp <= (count_nxt >= BP_THR);
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);

      if (pop) begin
        chk_vld            <= 1'b1;
        {chk_dst, chk_dat} <= mem[rd_ptr];
      end else if (ce) begin
        chk_vld <= 1'b0;
      end

      // Erroneous packets are still counted and recorded
      if (chk_fire) begin
        if (rx_count != '1) rx_count <= rx_count + 32'd1;
        if (src_ok) sb[sb_idx] <= 1'b1;
      end

      if (err_evt && !err) begin
        err      <= 1'b1;
        err_code <= evt_code;
      end
    end
  end

endmodule

// File: tb/tb_client_sink.sv
// Directed bench for client_sink: N=4, POSX=1, EXPECTED=3, DEPTH=8, SKID=2, full drain rate.
module tb_client_sink;
  localparam int A_W = 3;
  localparam int D_W = 32;

  logic             clk = 1'b0;
  logic             rst, ce, c_i_v;
  logic [A_W+D_W:0] c_i;
  logic             c_i_bp, err, done;
  logic [31:0]      rx_count;
  logic [2:0]       err_code;

  int checks = 0;
  int errors = 0;

  client_sink #(
    .N(4), .D_W(D_W), .A_W(A_W), .POSX(1), .LIMIT(16), .EXPECTED(3),
    .DEPTH(8), .SKID(2), .DRAIN_RATE(100)
  ) dut (
    .clk(clk), .rst(rst), .ce(ce), .c_i(c_i), .c_i_v(c_i_v),
    .c_i_bp(c_i_bp), .rx_count(rx_count), .err(err), .err_code(err_code), .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_pkt(input logic [2:0] dst, input logic [31:0] id);
    c_i   = {1'b0, dst, id};
    c_i_v = 1'b1;
    tick();
    c_i_v = 1'b0;
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    c_i_v = 1'b0;
    tick();
    tick();
    rst   = 1'b0;
  endtask

  task automatic test_reset();
    ce = 1'b1;
    do_reset();
    checks++; if (c_i_bp !== 1'b0)    begin errors++; $display("FAIL reset_bp: got %0d expected 0", c_i_bp); end
    checks++; if (rx_count !== 32'd0) begin errors++; $display("FAIL reset_rx: got %0d expected 0", rx_count); end
    checks++; if (err !== 1'b0)       begin errors++; $display("FAIL reset_err: got %0d expected 0", err); end
    checks++; if (err_code !== 3'd0)  begin errors++; $display("FAIL reset_code: got %0d expected 0", err_code); end
    checks++; if (done !== 1'b0)      begin errors++; $display("FAIL reset_done: got %0d expected 0", done); end
  endtask

  task automatic test_basic();
    int cyc;
    ce = 1'b1;
    do_reset();
    push_pkt(3'd1, 32'd0);
    push_pkt(3'd1, 32'd33);
    checks++; if (rx_count !== 32'd0) begin errors++; $display("FAIL basic_lat0: got %0d expected 0", rx_count); end
    push_pkt(3'd1, 32'd50);
    checks++; if (rx_count !== 32'd1) begin errors++; $display("FAIL basic_lat2: got %0d expected 1", rx_count); end
    cyc = 0;
    while (done !== 1'b1 && cyc < 4) begin
      tick();
      cyc++;
    end
    checks++; if (done !== 1'b1)      begin errors++; $display("FAIL basic_done: got %0d expected 1 (waited %0d)", done, cyc); end
    checks++; if (rx_count !== 32'd3) begin errors++; $display("FAIL basic_rx: got %0d expected 3", rx_count); end
    checks++; if (err !== 1'b0)       begin errors++; $display("FAIL basic_err: got %0d expected 0", err); end
  endtask

  task automatic test_backpressure();
    ce = 1'b0;
    do_reset();
    for (int i = 0; i < 5; i++) push_pkt(3'd1, 32'(i));
    checks++; if (c_i_bp !== 1'b0) begin errors++; $display("FAIL bp_5: got %0d expected 0", c_i_bp); end
    push_pkt(3'd1, 32'd5);
    checks++; if (c_i_bp !== 1'b1) begin errors++; $display("FAIL bp_6: got %0d expected 1", c_i_bp); end
    push_pkt(3'd1, 32'd6);
    push_pkt(3'd1, 32'd7);
    checks++; if (err !== 1'b0)    begin errors++; $display("FAIL bp_8_err: got %0d expected 0", err); end
    push_pkt(3'd1, 32'd8);
    checks++; if (err !== 1'b1)      begin errors++; $display("FAIL ovf_err: got %0d expected 1", err); end
    checks++; if (err_code !== 3'd5) begin errors++; $display("FAIL ovf_code: got %0d expected 5", err_code); end
    ce = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    checks++; if (rx_count !== 32'd8) begin errors++; $display("FAIL err_drain_rx: got %0d expected 8", rx_count); end
    checks++; if (c_i_bp !== 1'b0)    begin errors++; $display("FAIL err_drain_bp: got %0d expected 0", c_i_bp); end
  endtask

  task automatic test_full_push_pop();
    ce = 1'b0;
    do_reset();
    for (int i = 0; i < 8; i++) push_pkt(3'd1, 32'(i));
    checks++; if (dut.count !== 4'd8) begin errors++; $display("FAIL full_occ: got %0d expected 8", dut.count); end
    ce = 1'b1;
    push_pkt(3'd1, 32'd8);
    checks++; if (err !== 1'b0)         begin errors++; $display("FAIL pp_err: got %0d expected 0", err); end
    checks++; if (dut.count !== 4'd8)   begin errors++; $display("FAIL pp_occ: got %0d expected 8", dut.count); end
    checks++; if (dut.chk_dat !== 32'd0) begin errors++; $display("FAIL pp_order0: got %0d expected 0", dut.chk_dat); end
    for (int k = 1; k <= 8; k++) begin
      tick();
      checks++; if (dut.chk_dat !== 32'(k)) begin errors++; $display("FAIL pp_order%0d: got %0d expected %0d", k, dut.chk_dat, k); end
    end
    tick();
    tick();
    checks++; if (rx_count !== 32'd9) begin errors++; $display("FAIL pp_rx: got %0d expected 9", rx_count); end
    checks++; if (err !== 1'b0)       begin errors++; $display("FAIL pp_err_end: got %0d expected 0", err); end
  endtask

  task automatic test_misroute();
    ce = 1'b1;
    do_reset();
    push_pkt(3'd2, 32'd0);
    tick();
    tick();
    checks++; if (err_code !== 3'd1) begin errors++; $display("FAIL mis_code: got %0d expected 1", err_code); end
    checks++; if (err !== 1'b1)      begin errors++; $display("FAIL mis_err: got %0d expected 1", err); end
    push_pkt(3'd1, 32'd33);
    tick(); tick(); tick();
    checks++; if (err_code !== 3'd1)  begin errors++; $display("FAIL mis_sticky: got %0d expected 1", err_code); end
    checks++; if (rx_count !== 32'd2) begin errors++; $display("FAIL mis_rx: got %0d expected 2", rx_count); end
  endtask

  task automatic test_dup_badsrc();
    ce = 1'b1;
    do_reset();
    push_pkt(3'd1, 32'd33);
    push_pkt(3'd1, 32'd33);
    tick(); tick(); tick();
    checks++; if (err_code !== 3'd4)  begin errors++; $display("FAIL dup_code: got %0d expected 4", err_code); end
    checks++; if (rx_count !== 32'd2) begin errors++; $display("FAIL dup_rx: got %0d expected 2", rx_count); end
    do_reset();
    push_pkt(3'd1, 32'd17);
    tick(); tick(); tick();
    checks++; if (err_code !== 3'd2) begin errors++; $display("FAIL badsrc_code: got %0d expected 2", err_code); end
    checks++; if (err !== 1'b1)      begin errors++; $display("FAIL badsrc_err: got %0d expected 1", err); end
  endtask

  task automatic test_extra_and_rst();
    int cyc;
    ce = 1'b1;
    do_reset();
    push_pkt(3'd1, 32'd0);
    push_pkt(3'd1, 32'd33);
    push_pkt(3'd1, 32'd50);
    cyc = 0;
    while (done !== 1'b1 && cyc < 6) begin
      tick();
      cyc++;
    end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL extra_pre_done: got %0d expected 1", done); end
    push_pkt(3'd1, 32'd2);
    tick(); tick(); tick();
    checks++; if (done !== 1'b0)      begin errors++; $display("FAIL extra_done: got %0d expected 0", done); end
    checks++; if (err !== 1'b1)       begin errors++; $display("FAIL extra_err: got %0d expected 1", err); end
    checks++; if (err_code !== 3'd6)  begin errors++; $display("FAIL extra_code: got %0d expected 6", err_code); end
    checks++; if (rx_count !== 32'd4) begin errors++; $display("FAIL extra_rx: got %0d expected 4", rx_count); end
    ce = 1'b0;
    for (int i = 0; i < 7; i++) push_pkt(3'd1, 32'(16 + i));
    checks++; if (c_i_bp !== 1'b1) begin errors++; $display("FAIL burst_bp: got %0d expected 1", c_i_bp); end
    c_i   = {1'b0, 3'd1, 32'd40};
    c_i_v = 1'b1;
    rst   = 1'b1;
    tick();
    checks++; if (c_i_bp !== 1'b0)    begin errors++; $display("FAIL rst_bp: got %0d expected 0", c_i_bp); end
    checks++; if (rx_count !== 32'd0) begin errors++; $display("FAIL rst_rx: got %0d expected 0", rx_count); end
    checks++; if (err !== 1'b0)       begin errors++; $display("FAIL rst_err: got %0d expected 0", err); end
    checks++; if (err_code !== 3'd0)  begin errors++; $display("FAIL rst_code: got %0d expected 0", err_code); end
    checks++; if (done !== 1'b0)      begin errors++; $display("FAIL rst_done: got %0d expected 0", done); end
    checks++; if (dut.count !== 4'd0) begin errors++; $display("FAIL rst_occ: got %0d expected 0", dut.count); end
    rst   = 1'b0;
    c_i_v = 1'b0;
  endtask

  initial begin
    rst   = 1'b1;
    ce    = 1'b0;
    c_i   = '0;
    c_i_v = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_full_push_pop();
    test_misroute();
    test_dup_badsrc();
    test_extra_and_rst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
